// File: rtl/if_id_decode_pkg.sv
// Shared CPU definitions: MIPS opcode/funct codes, ALU operation encoding and the
// decoded control bundle passed down the pipeline.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_SLT = 3'd2,
        ALU_AND = 3'd3,
        ALU_OR  = 3'd4
    } alu_op_t;

    typedef struct packed {
        logic    branch;
        logic    jump;
        logic    jr;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    alu_src;
        logic    reg_dst;
        alu_op_t alu_op;
    } ctrl_t;

    // Instructions whose rt field is a source operand and can therefore need a loaded value.
    function automatic logic reads_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    endfunction

endpackage

// File: rtl/if_id_decode_if.sv
// Fetch-side inputs and decoded ID/EX outputs of the if_id_decode stage.
interface if_id_decode_if #(
    parameter int ADDR_W  = 30,
    parameter int INSTR_W = 32
);
    logic [INSTR_W-1:0] instr_in;
    logic [ADDR_W-1:0]  pc_in;
    logic               flush;
    logic               stall_out;
    logic               ex_valid;
    logic [ADDR_W-1:0]  ex_pc;
    logic [4:0]         ex_rs;
    logic [4:0]         ex_rt;
    logic [4:0]         ex_rd;
    logic [15:0]        ex_imm16;
    logic [25:0]        ex_target;
    logic               ex_branch;
    logic               ex_jump;
    logic               ex_jr;
    logic               ex_reg_write;
    logic               ex_mem_read;
    logic               ex_mem_write;
    logic               ex_alu_src;
    logic               ex_reg_dst;
    logic [2:0]         ex_alu_op;
    logic               ex_illegal;

    modport master (
        output instr_in, pc_in, flush,
        input  stall_out, ex_valid, ex_pc, ex_rs, ex_rt, ex_rd, ex_imm16, ex_target,
               ex_branch, ex_jump, ex_jr, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_alu_src, ex_reg_dst, ex_alu_op, ex_illegal
    );

    modport slave (
        input  instr_in, pc_in, flush,
        output stall_out, ex_valid, ex_pc, ex_rs, ex_rt, ex_rd, ex_imm16, ex_target,
               ex_branch, ex_jump, ex_jr, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_alu_src, ex_reg_dst, ex_alu_op, ex_illegal
    );
endinterface

// File: rtl/if_id_decode_ctrl.sv
// Combinational MIPS-subset decoder: opcode/funct to control bundle, flagging anything
// outside the supported subset as illegal with all control bits cleared.
module ctrl_decoder
    import cpu_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output ctrl_t      ctrl_o,
    output logic       illegal_o
);
    always_comb begin
        ctrl_o    = '0;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
                case (funct_i)
                    FN_ADD:  ctrl_o.alu_op = ALU_ADD;
                    FN_SUB:  ctrl_o.alu_op = ALU_SUB;
                    FN_SLT:  ctrl_o.alu_op = ALU_SLT;
                    FN_AND:  ctrl_o.alu_op = ALU_AND;
                    FN_OR:   ctrl_o.alu_op = ALU_OR;
                    FN_JR: begin
                        ctrl_o    = '0;
                        ctrl_o.jr = 1'b1;
                    end
                    default: begin
                        ctrl_o    = '0;
                        illegal_o = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
            end
            OP_SW: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
            end
            OP_BEQ: begin
                ctrl_o.branch = 1'b1;
                ctrl_o.alu_op = ALU_SUB;
            end
            OP_J:    ctrl_o.jump = 1'b1;
            OP_ADDI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/if_id_decode.sv
// IF/ID latch feeding a registered ID/EX latch, with load-use stall and flush handling.
module if_id_decode
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 30,
    parameter int INSTR_W = 32,
    parameter bit HAZ_EN  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    if_id_decode_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] pc;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [15:0]       imm16;
        logic [25:0]       target;
        ctrl_t             ctrl;
        logic              illegal;
    } idex_t;

    logic               ifid_valid_q, ifid_valid_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
    idex_t              idex_q, idex_d;

    ctrl_t      dec_ctrl;
    logic       dec_illegal;
    logic       hazard;
    logic [4:0] if_rs;
    logic [4:0] if_rt;

    ctrl_decoder u_ctrl_decoder (
        .opcode_i  (ifid_instr_q[31:26]),
        .funct_i   (ifid_instr_q[5:0]),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal)
    );

    assign if_rs = ifid_instr_q[25:21];
    assign if_rt = ifid_instr_q[20:16];

    // A load into $0 never creates a dependency, since $0 is hardwired.
    assign hazard = HAZ_EN && idex_q.valid && idex_q.ctrl.mem_read && (idex_q.rt != 5'd0)
                    && ifid_valid_q
                    && ((idex_q.rt == if_rs)
                        || (reads_rt(ifid_instr_q[31:26]) && (idex_q.rt == if_rt)));

    assign bus.stall_out = hazard && !bus.flush;

    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        idex_d       = '0;
        if (bus.flush) begin
            ifid_valid_d = 1'b0;
        end else if (!hazard) begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = bus.instr_in;
            ifid_pc_d    = bus.pc_in;
            if (ifid_valid_q) begin
                if (dec_illegal) begin
                    idex_d.illegal = 1'b1;
                end else begin
                    idex_d.valid  = 1'b1;
                    idex_d.pc     = ifid_pc_q;
                    idex_d.rs     = if_rs;
                    idex_d.rt     = if_rt;
                    idex_d.rd     = ifid_instr_q[15:11];
                    idex_d.imm16  = ifid_instr_q[15:0];
                    idex_d.target = ifid_instr_q[25:0];
                    idex_d.ctrl   = dec_ctrl;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
            idex_q       <= '0;
        end else begin
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            idex_q       <= idex_d;
        end
    end

    assign bus.ex_valid     = idex_q.valid;
    assign bus.ex_pc        = idex_q.pc;
    assign bus.ex_rs        = idex_q.rs;
    assign bus.ex_rt        = idex_q.rt;
    assign bus.ex_rd        = idex_q.rd;
    assign bus.ex_imm16     = idex_q.imm16;
    assign bus.ex_target    = idex_q.target;
    assign bus.ex_branch    = idex_q.ctrl.branch;
    assign bus.ex_jump      = idex_q.ctrl.jump;
    assign bus.ex_jr        = idex_q.ctrl.jr;
    assign bus.ex_reg_write = idex_q.ctrl.reg_write;
    assign bus.ex_mem_read  = idex_q.ctrl.mem_read;
    assign bus.ex_mem_write = idex_q.ctrl.mem_write;
    assign bus.ex_alu_src   = idex_q.ctrl.alu_src;
    assign bus.ex_reg_dst   = idex_q.ctrl.reg_dst;
    assign bus.ex_alu_op    = idex_q.ctrl.alu_op;
    assign bus.ex_illegal   = idex_q.illegal;
endmodule

// File: tb/tb_if_id_decode.sv
// Self-checking bench for if_id_decode: a table-driven pipeline model compared every
// cycle, plus directed instruction sequences with hand-computed expectations.
module tb_if_id_decode;
    localparam int ADDR_W  = 30;
    localparam int INSTR_W = 32;
    localparam bit HAZ_EN  = 1'b1;

    localparam logic [31:0] FILL  = 32'h2001_0001;
    localparam logic [31:0] LW8   = 32'h8D28_0004;
    localparam logic [31:0] ADD10 = 32'h010B_5020;
    localparam logic [31:0] BEQ   = 32'h1109_0003;
    localparam logic [31:0] JMP   = 32'h0800_0040;
    localparam logic [31:0] JR31  = 32'h03E0_0008;
    localparam logic [31:0] ILL   = 32'hFC00_0000;
    localparam logic [31:0] LW0   = 32'h8D20_0000;
    localparam logic [31:0] ADD0  = 32'h0000_5020;
    localparam int          NPROG = 13;
    localparam int          NROWS = 11;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectorCount = 0;
    int   missCount   = 0;

    if_id_decode_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    if_id_decode #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .HAZ_EN(HAZ_EN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [29:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm16;
        logic [25:0] target;
        logic        branch;
        logic        jump;
        logic        jr;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
        logic        aluSrc;
        logic        regDst;
        logic [2:0]  aluOp;
        logic        illegal;
    } exOut_t;

    // ctrl order: branch jump jr regWrite memRead memWrite aluSrc regDst
    typedef struct packed {
        logic [5:0] op;
        logic       anyFn;
        logic [5:0] fn;
        logic [7:0] ctrl;
        logic [2:0] aluOp;
    } row_t;

    row_t decodeTable [NROWS] = '{
        {6'h00, 1'b0, 6'h20, 8'b0001_0001, 3'd0},
        {6'h00, 1'b0, 6'h22, 8'b0001_0001, 3'd1},
        {6'h00, 1'b0, 6'h2A, 8'b0001_0001, 3'd2},
        {6'h00, 1'b0, 6'h24, 8'b0001_0001, 3'd3},
        {6'h00, 1'b0, 6'h25, 8'b0001_0001, 3'd4},
        {6'h00, 1'b0, 6'h08, 8'b0010_0000, 3'd0},
        {6'h23, 1'b1, 6'h00, 8'b0001_1010, 3'd0},
        {6'h2B, 1'b1, 6'h00, 8'b0000_0110, 3'd0},
        {6'h04, 1'b1, 6'h00, 8'b1000_0000, 3'd1},
        {6'h02, 1'b1, 6'h00, 8'b0100_0000, 3'd0},
        {6'h08, 1'b1, 6'h00, 8'b0001_0010, 3'd0}
    };

    logic [31:0] prog [NPROG] = '{
        32'h8D28_0004, 32'h010B_5020, 32'h0108_6020, 32'h0022_1822, 32'h0022_182A,
        32'h0022_1824, 32'h0022_1825, 32'h8D28_0004, 32'hAD28_0008, 32'h8D28_0004,
        32'h8D28_0004, 32'h0022_1821, 32'h2001_0001
    };

    logic        mIfValid;
    logic [31:0] mIfWord;
    logic [29:0] mIfPc;
    exOut_t      mEx;

    function automatic exOut_t expectDecode(input logic [31:0] w, input logic [29:0] pc);
        exOut_t e;
        e = '0;
        for (int i = 0; i < NROWS; i++) begin
            if (decodeTable[i].op == w[31:26] && (decodeTable[i].anyFn || decodeTable[i].fn == w[5:0])) begin
                e.valid  = 1'b1;
                e.pc     = pc;
                e.rs     = w[25:21];
                e.rt     = w[20:16];
                e.rd     = w[15:11];
                e.imm16  = w[15:0];
                e.target = w[25:0];
                {e.branch, e.jump, e.jr, e.regWrite, e.memRead, e.memWrite, e.aluSrc, e.regDst} = decodeTable[i].ctrl;
                e.aluOp  = decodeTable[i].aluOp;
            end
        end
        if (!e.valid) e.illegal = 1'b1;
        return e;
    endfunction

    function automatic bit modelHazard();
        logic [5:0] op;
        op = mIfWord[31:26];
        if (!HAZ_EN || !mEx.valid || !mEx.memRead || mEx.rt == 5'd0 || !mIfValid) return 1'b0;
        if (mIfWord[25:21] == mEx.rt) return 1'b1;
        return (op == 6'h00 || op == 6'h2B || op == 6'h04) && (mIfWord[20:16] == mEx.rt);
    endfunction

    // Model state advances on the same edge as the DUT, using the inputs driven last cycle.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mIfValid <= 1'b0;
            mIfWord  <= '0;
            mIfPc    <= '0;
            mEx      <= '0;
        end else if (bus.flush) begin
            mIfValid <= 1'b0;
            mEx      <= '0;
        end else if (modelHazard()) begin
            mEx      <= '0;
        end else begin
            mEx      <= mIfValid ? expectDecode(mIfWord, mIfPc) : '0;
            mIfValid <= 1'b1;
            mIfWord  <= bus.instr_in;
            mIfPc    <= bus.pc_in;
        end
    end

    function automatic logic [127:0] dutSnapshot();
        exOut_t d;
        d.valid    = bus.ex_valid;
        d.pc       = bus.ex_pc;
        d.rs       = bus.ex_rs;
        d.rt       = bus.ex_rt;
        d.rd       = bus.ex_rd;
        d.imm16    = bus.ex_imm16;
        d.target   = bus.ex_target;
        d.branch   = bus.ex_branch;
        d.jump     = bus.ex_jump;
        d.jr       = bus.ex_jr;
        d.regWrite = bus.ex_reg_write;
        d.memRead  = bus.ex_mem_read;
        d.memWrite = bus.ex_mem_write;
        d.aluSrc   = bus.ex_alu_src;
        d.regDst   = bus.ex_reg_dst;
        d.aluOp    = bus.ex_alu_op;
        d.illegal  = bus.ex_illegal;
        return 128'({bus.stall_out, d});
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkField(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkOutput(name, 128'(actual), 128'(expected));
    endtask

    task automatic applyStimulus(input logic [31:0] word, input logic [29:0] pc, input logic fl);
        @(posedge clk);
        #1;
        bus.instr_in = word;
        bus.pc_in    = pc;
        bus.flush    = fl;
    endtask

    always @(negedge clk) begin
        if (rst) checkOutput("cycle", dutSnapshot(), 128'({modelHazard() && !bus.flush, mEx}));
    end

    initial begin
        int idx;
        int guard;
        bus.instr_in = FILL;
        bus.pc_in    = '0;
        bus.flush    = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("resetInit", dutSnapshot(), 128'd0);
        rst = 1'b1;

        $display("[TB] T2 lw decode");
        applyStimulus(LW8, 30'h10, 1'b0);
        applyStimulus(FILL, 30'h11, 1'b0);
        applyStimulus(FILL, 30'h12, 1'b0);
        @(negedge clk);
        checkField("T2 valid", 32'(bus.ex_valid), 32'd1);
        checkField("T2 memRead", 32'(bus.ex_mem_read), 32'd1);
        checkField("T2 regWrite", 32'(bus.ex_reg_write), 32'd1);
        checkField("T2 aluSrc", 32'(bus.ex_alu_src), 32'd1);
        checkField("T2 rs", 32'(bus.ex_rs), 32'd9);
        checkField("T2 rt", 32'(bus.ex_rt), 32'd8);
        checkField("T2 imm16", 32'(bus.ex_imm16), 32'h4);
        checkField("T2 pc", 32'(bus.ex_pc), 32'h10);

        $display("[TB] T1 asynchronous reset");
        #2 rst = 1'b0;
        #1 checkOutput("T1 asyncReset", dutSnapshot(), 128'd0);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] T3 load-use stall");
        applyStimulus(LW8, 30'h20, 1'b0);
        applyStimulus(ADD10, 30'h21, 1'b0);
        applyStimulus(ADD10, 30'h21, 1'b0);
        @(negedge clk);
        checkField("T3 stall", 32'(bus.stall_out), 32'd1);
        applyStimulus(FILL, 30'h22, 1'b0);
        @(negedge clk);
        checkField("T3 bubbleValid", 32'(bus.ex_valid), 32'd0);
        checkField("T3 stallOnce", 32'(bus.stall_out), 32'd0);
        applyStimulus(FILL, 30'h23, 1'b0);
        @(negedge clk);
        checkField("T3 addValid", 32'(bus.ex_valid), 32'd1);
        checkField("T3 addRs", 32'(bus.ex_rs), 32'd8);
        checkField("T3 addRd", 32'(bus.ex_rd), 32'd10);
        checkField("T3 addAluOp", 32'(bus.ex_alu_op), 32'd0);

        $display("[TB] T4 flush beats hazard");
        applyStimulus(LW8, 30'h30, 1'b0);
        applyStimulus(ADD10, 30'h31, 1'b0);
        applyStimulus(ADD10, 30'h31, 1'b1);
        @(negedge clk);
        checkField("T4 stall", 32'(bus.stall_out), 32'd0);
        applyStimulus(FILL, 30'h40, 1'b0);
        @(negedge clk);
        checkField("T4 bubble1", 32'(bus.ex_valid), 32'd0);
        applyStimulus(FILL, 30'h41, 1'b0);
        @(negedge clk);
        checkField("T4 bubble2", 32'(bus.ex_valid), 32'd0);
        applyStimulus(FILL, 30'h42, 1'b0);
        @(negedge clk);
        checkField("T4 resumeValid", 32'(bus.ex_valid), 32'd1);
        checkField("T4 resumePc", 32'(bus.ex_pc), 32'h40);

        $display("[TB] T5 control transfers");
        applyStimulus(BEQ, 30'h50, 1'b0);
        applyStimulus(JMP, 30'h51, 1'b0);
        applyStimulus(JR31, 30'h52, 1'b0);
        @(negedge clk);
        checkField("T5 beqBranch", 32'(bus.ex_branch), 32'd1);
        checkField("T5 beqAluOp", 32'(bus.ex_alu_op), 32'd1);
        applyStimulus(FILL, 30'h53, 1'b0);
        @(negedge clk);
        checkField("T5 jJump", 32'(bus.ex_jump), 32'd1);
        checkField("T5 jTarget", 32'(bus.ex_target), 32'h40);
        applyStimulus(FILL, 30'h54, 1'b0);
        @(negedge clk);
        checkField("T5 jrJr", 32'(bus.ex_jr), 32'd1);
        checkField("T5 jrRs", 32'(bus.ex_rs), 32'd31);

        $display("[TB] T6 illegal and $0 load");
        applyStimulus(ILL, 30'h60, 1'b0);
        applyStimulus(FILL, 30'h61, 1'b0);
        applyStimulus(FILL, 30'h62, 1'b0);
        @(negedge clk);
        checkField("T6 illegal", 32'(bus.ex_illegal), 32'd1);
        checkField("T6 illValid", 32'(bus.ex_valid), 32'd0);
        applyStimulus(FILL, 30'h63, 1'b0);
        @(negedge clk);
        checkField("T6 illegalPulse", 32'(bus.ex_illegal), 32'd0);
        applyStimulus(LW0, 30'h70, 1'b0);
        applyStimulus(ADD0, 30'h71, 1'b0);
        applyStimulus(FILL, 30'h72, 1'b0);
        @(negedge clk);
        checkField("T6 noZeroStall", 32'(bus.stall_out), 32'd0);

        $display("[TB] mixed program with fetch holding on stall");
        idx   = 0;
        guard = 0;
        while (idx < NPROG && guard < 4 * NPROG) begin
            applyStimulus(prog[idx], 30'h100 + 30'(idx), 1'b0);
            @(negedge clk);
            if (!modelHazard()) idx++;
            guard++;
        end
        checkField("program progress", 32'(idx), 32'(NPROG));
        repeat (3) applyStimulus(FILL, 30'h200, 1'b0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
